// File: rtl/seq_signed_divider.sv
// Sequential signed divider: one restoring iteration per clock on unsigned magnitudes,
// followed by a single sign-fix cycle. Truncates toward zero; flags divide-by-zero and overflow.
module seq_signed_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo;      // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic             a_neg;
    logic             q_neg;
    logic             dz;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;
    logic [WIDTH-1:0] q_fix, r_src, r_fix;

    // Unsigned WIDTH-bit magnitudes: the most negative value maps to 2^(WIDTH-1) exactly.
    assign a_mag = A[WIDTH-1] ? -A : A;
    assign b_mag = B[WIDTH-1] ? -B : B;

    // Trial subtraction; the true difference is below dvs when it fits, so WIDTH bits suffice.
    assign shifted = {rem, quo[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, dvs});
    assign diff    = shifted[WIDTH-1:0] - dvs;

    assign q_fix = q_neg ? -quo : quo;
    assign r_src = dz ? quo : rem;
    assign r_fix = a_neg ? -r_src : r_src;

    // NOTE: asynchronous active-low reset sits in the sensitivity list so it acts without a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch is inferred.
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (B == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nx = FIX;
                end
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            quo         <= '0;
            rem         <= '0;
            dvs         <= '0;
            a_neg       <= 1'b0;
            q_neg       <= 1'b0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            Quotient    <= '0;
            Remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        quo   <= a_mag;
                        dvs   <= b_mag;
                        rem   <= '0;
                        a_neg <= A[WIDTH-1];
                        q_neg <= A[WIDTH-1] ^ B[WIDTH-1];
                        dz    <= (B == '0);
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (fits) begin
                        rem <= diff;
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    Quotient    <= dz ? '1 : q_fix;
                    Remainder   <= r_fix;
                    div_by_zero <= dz;
                    // A positive quotient magnitude of 2^(WIDTH-1) only arises from MIN / -1.
                    overflow    <= ~dz & quo[WIDTH-1] & ~q_neg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: directed corner cases plus randomized
// back-to-back operations checked against a 64-bit arithmetic reference model.
module tb_seq_signed_divider;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] Quotient, Remainder;
    logic        busy, done, div_by_zero, overflow;

    int vec  = 0;
    int errs = 0;

    seq_signed_divider #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
        .Quotient(Quotient), .Remainder(Remainder), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference: C-style truncating division on 64-bit signed values.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output logic ov);
        longint sa, sb, lq, lr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1; ov = 1'b0;
        end else begin
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
            dz = 1'b0;
            ov = (lq > 64'sd2147483647);
        end
    endfunction

    // Called at a falling edge; returns at the falling edge where done is seen.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt, output logic got);
        A = a; B = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        lat = 0; bcnt = 0; got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) bcnt++;
                lat++;
                @(negedge clk);
            end
        end
        vec++;
        if (!got) begin
            errs++;
            $display("FAIL timeout a=%h b=%h: done not seen within 100 cycles", a, b);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vec++;
        if ({Quotient, Remainder, busy, done, div_by_zero, overflow} !== 68'd0) begin
            errs++;
            $display("FAIL reset_state: got Q=%h R=%h busy=%b done=%b dz=%b ov=%b, required all 0",
                     Quotient, Remainder, busy, done, div_by_zero, overflow);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic;
        int lat, bcnt;
        logic got;
        do_op(32'd100, 32'd7, lat, bcnt, got);
        vec++;
        if (lat != 33 || bcnt != 33 || busy !== 1'b0) begin
            errs++;
            $display("FAIL basic_timing: got lat=%0d busy_cycles=%0d busy@done=%b, required 33/33/0",
                     lat, bcnt, busy);
        end
        vec++;
        if (Quotient !== 32'd14 || Remainder !== 32'd2 || div_by_zero !== 1'b0 || overflow !== 1'b0) begin
            errs++;
            $display("FAIL basic_result: got Q=%0d R=%0d dz=%b ov=%b, required 14 2 0 0",
                     $signed(Quotient), $signed(Remainder), div_by_zero, overflow);
        end
        @(negedge clk);
        vec++;
        if (done !== 1'b0) begin
            errs++;
            $display("FAIL done_pulse: got done=%b one cycle later, required 0", done);
        end
        repeat (4) @(negedge clk);
        vec++;
        if (Quotient !== 32'd14 || Remainder !== 32'd2 || busy !== 1'b0) begin
            errs++;
            $display("FAIL result_hold: got Q=%0d R=%0d busy=%b, required 14 2 0",
                     $signed(Quotient), $signed(Remainder), busy);
        end
    endtask

    task automatic test_quadrants;
        logic [31:0] ta [3] = '{-32'sd100, 32'sd100, -32'sd100};
        logic [31:0] tb [3] = '{32'sd7, -32'sd7, -32'sd7};
        logic [31:0] tq [3] = '{-32'sd14, -32'sd14, 32'sd14};
        logic [31:0] tr [3] = '{-32'sd2, 32'sd2, -32'sd2};
        int lat, bcnt;
        logic got;
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb[i], lat, bcnt, got);
            vec++;
            if (Quotient !== tq[i] || Remainder !== tr[i] || {div_by_zero, overflow} !== 2'b00) begin
                errs++;
                $display("FAIL quadrant_%0d: got Q=%0d R=%0d dz=%b ov=%b, required Q=%0d R=%0d flags 0",
                         i, $signed(Quotient), $signed(Remainder), div_by_zero, overflow,
                         $signed(tq[i]), $signed(tr[i]));
            end
        end
    endtask

    task automatic test_div_zero;
        logic [31:0] ta [2] = '{32'd5, -32'sd9};
        int lat, bcnt;
        logic got;
        for (int i = 0; i < 2; i++) begin
            do_op(ta[i], 32'd0, lat, bcnt, got);
            vec++;
            if (lat != 1 || bcnt != 1) begin
                errs++;
                $display("FAIL div_zero_timing_%0d: got lat=%0d busy_cycles=%0d, required 1/1", i, lat, bcnt);
            end
            vec++;
            if (Quotient !== 32'hFFFF_FFFF || Remainder !== ta[i] || div_by_zero !== 1'b1 || overflow !== 1'b0) begin
                errs++;
                $display("FAIL div_zero_result_%0d: got Q=%h R=%h dz=%b ov=%b, required FFFFFFFF %h 1 0",
                         i, Quotient, Remainder, div_by_zero, overflow, ta[i]);
            end
        end
    endtask

    task automatic test_overflow;
        int lat, bcnt;
        logic got;
        do_op(32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt, got);
        vec++;
        if (lat != 33 || Quotient !== 32'h8000_0000 || Remainder !== 32'd0 ||
            overflow !== 1'b1 || div_by_zero !== 1'b0) begin
            errs++;
            $display("FAIL overflow_min_by_m1: got lat=%0d Q=%h R=%h ov=%b dz=%b, required 33 80000000 0 1 0",
                     lat, Quotient, Remainder, overflow, div_by_zero);
        end
        do_op(32'h7FFF_FFFF, 32'h8000_0000, lat, bcnt, got);
        vec++;
        if (Quotient !== 32'd0 || Remainder !== 32'h7FFF_FFFF || {div_by_zero, overflow} !== 2'b00) begin
            errs++;
            $display("FAIL max_by_min: got Q=%h R=%h dz=%b ov=%b, required 0 7FFFFFFF 0 0",
                     Quotient, Remainder, div_by_zero, overflow);
        end
    endtask

    task automatic test_start_ignored;
        int lat;
        logic got;
        A = 32'd1000; B = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0; got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (lat == 10) begin A = 32'd9; B = 32'd2; start = 1'b1; end
                if (lat == 11) start = 1'b0;
                lat++;
                @(negedge clk);
            end
        end
        vec++;
        if (!got || lat != 33 || Quotient !== 32'd333 || Remainder !== 32'd1) begin
            errs++;
            $display("FAIL start_ignored: got done=%b lat=%0d Q=%0d R=%0d, required 1 33 333 1",
                     got, lat, Quotient, Remainder);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int lat, bcnt;
        logic got, seen_done;
        A = 32'd1000; B = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        seen_done = 1'b0;
        for (int c = 1; c < 20; c++) begin
            if (done) seen_done = 1'b1;
            if (c == 10) begin A = 32'd9; B = 32'd2; start = 1'b1; end
            if (c == 11) start = 1'b0;
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        vec++;
        if (seen_done || {Quotient, Remainder, busy, done, div_by_zero, overflow} !== 68'd0) begin
            errs++;
            $display("FAIL reset_abort: got early_done=%b Q=%h R=%h busy=%b done=%b, required 0 and all outputs 0",
                     seen_done, Quotient, Remainder, busy, done);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        do_op(32'd9, 32'd2, lat, bcnt, got);
        vec++;
        if (lat != 33 || Quotient !== 32'd4 || Remainder !== 32'd1) begin
            errs++;
            $display("FAIL after_reset: got lat=%0d Q=%0d R=%0d, required 33 4 1", lat, Quotient, Remainder);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, b, mq, mr, abs_r, abs_b;
        logic        mdz, mov, got;
        int          lat, bcnt;
        longint      rec;
        for (int n = 0; n < 500; n++) begin
            a = 32'($urandom) >> $urandom_range(0, 16);
            if ($urandom_range(0, 1) == 1) a = -a;
            b = 32'($urandom) >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) b = -b;
            if (b == 32'd0) b = 32'd3;
            model(a, b, mq, mr, mdz, mov);
            do_op(a, b, lat, bcnt, got);
            vec++;
            if (lat != 33 || Quotient !== mq || Remainder !== mr || {div_by_zero, overflow} !== {mdz, mov}) begin
                errs++;
                $display("FAIL random_%0d a=%h b=%h: got lat=%0d Q=%h R=%h dz=%b ov=%b, required 33 %h %h %b %b",
                         n, a, b, lat, Quotient, Remainder, div_by_zero, overflow, mq, mr, mdz, mov);
            end
            if (!mov) begin
                rec = longint'($signed(Quotient)) * longint'($signed(b)) + longint'($signed(Remainder));
                abs_r = Remainder[31] ? -Remainder : Remainder;
                abs_b = b[31] ? -b : b;
                vec++;
                if (rec != longint'($signed(a)) || abs_r >= abs_b ||
                    (Remainder != 32'd0 && Remainder[31] != a[31])) begin
                    errs++;
                    $display("FAIL identity_%0d a=%h b=%h: got Q*B+R=%0d Q=%h R=%h, required %0d with |R|<|B| and sign(R)=sign(A)",
                             n, a, b, rec, Quotient, Remainder, $signed(a));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_quadrants();
        test_div_zero();
        test_overflow();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/seq_signed_divider.md
SEQ_SIGNED_DIVIDER -- requirements
Module: seq_signed_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; all values below assume 32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 resets immediately, independent of clk).
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port A  input  WIDTH  signed two's-complement dividend; sampled on the accepting edge only.
REQ-006 SHALL have port B  input  WIDTH  signed two's-complement divisor; sampled on the accepting edge only.
REQ-007 SHALL have port Quotient  output  WIDTH  signed quotient, registered.
REQ-008 SHALL have port Remainder  output  WIDTH  signed remainder, registered.
REQ-009 SHALL have port busy  output  1  high from the cycle after acceptance until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse; results valid and stable from this cycle onward.
REQ-011 SHALL have port div_by_zero  output  1  status of last completed operation.
REQ-012 SHALL have port overflow  output  1  status of last completed operation.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX.
REQ-014 IDLE: start=1 at edge E0 SHALL latch |A|, |B|, sign(A), sign(A) xor sign(B), clear iteration counter, and go to CALC (or to FIX directly if B==0); start=0 stays IDLE.
REQ-015 CALC SHALL perform one restoring (shift, trial-subtract, conditional restore) iteration per cycle on unsigned magnitudes, 32 iterations at E1..E32, then go to FIX.
REQ-016 FIX (one cycle) SHALL negate the quotient magnitude if the signs differ, negate the remainder magnitude if A<0, write Quotient/Remainder/flags, pulse done, and return to IDLE.
REQ-017 Normal latency SHALL be: done high in the cycle after edge E33; busy high after E0 through E33 inclusive, low when done is high.
REQ-018 Division SHALL truncate toward zero: A == Quotient*B + Remainder; |Remainder| < |B|; Remainder is 0 or has the sign of A.
REQ-019 Magnitudes SHALL be taken as unsigned WIDTH-bit values so that |0x80000000| = 2^31 without loss.
REQ-020 B==0 SHALL yield Quotient=0xFFFFFFFF, Remainder=A, div_by_zero=1, overflow=0, with done in the cycle after E1 (skips CALC).
REQ-021 A=0x80000000, B=0xFFFFFFFF SHALL yield Quotient=0x80000000 (wrapped), Remainder=0, overflow=1, normal latency.
REQ-022 Flags SHALL be 0 for all other operations and updated only in FIX.
REQ-023 start while busy or in FIX SHALL be ignored (no queueing); start held high in IDLE after done SHALL begin a new operation on the next edge.
REQ-024 Quotient, Remainder and flags SHALL hold their values between done pulses; A/B changes after E0 SHALL not affect the result.

Reset
REQ-025 reset=0 SHALL asynchronously force IDLE, Quotient=0, Remainder=0, busy=0, done=0, div_by_zero=0, overflow=0, and clear all internal registers.
REQ-026 Reset asserted mid-operation SHALL abort it with no done pulse; the first edge after release with start=1 SHALL begin a fresh operation.

Verification
REQ-027 A=100, B=7, start pulse -> busy for 33 cycles, done one cycle later, Quotient=14, Remainder=2, flags 0.
REQ-028 Sign quadrants: (-100,7) -> (-14,-2); (100,-7) -> (-14,2); (-100,-7) -> (14,-2).
REQ-029 A=5, B=0 -> done in the cycle after E1, Quotient=0xFFFFFFFF, Remainder=5, div_by_zero=1.
REQ-030 A=0x80000000, B=-1 -> Quotient=0x80000000, Remainder=0, overflow=1; A=0x7FFFFFFF, B=0x80000000 -> Quotient=0, Remainder=0x7FFFFFFF.
REQ-031 Start 1000/3; pulse start with 9/2 at cycle 10; assert reset at cycle 20 -> second start ignored, no done, all outputs 0; after release 9/2 -> Quotient=4, Remainder=1.
REQ-032 500 random signed pairs with B!=0, back-to-back start -> every result satisfies REQ-018, checked by reconstructing A from Quotient*B+Remainder with the 64-bit signed product.
